// File: rtl/attendant_call_dispatcher.sv
// Purpose : round-robin dispatcher presenting one lit seat call at a time to the attendant.
// Latency : a lit seat seen in IDLE is presented one cycle later; an ack produces a one-cycle cancel pulse on the next cycle.
// Backpres: none; a presented call is held until it is acknowledged or the passenger withdraws it.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        synchronous active-low reset
//   seat_light     per-seat call light levels
//   attendant_ack  attendant acknowledges the presented call (level)
//   seat_cancel    one-hot, one-cycle cancel pulse to the serviced seat
//   active_valid   a call is being presented
//   active_seat    index of the presented seat (0 when nothing is presented)
//   call_pending   registered OR of seat_light
//   escalate       presented call left unacknowledged for ESC_CYCLES cycles
//   serviced_count acknowledged calls, saturating at 255
//
// Optional feature macro: CALL_ESCALATE_EN builds the escalation counter;
// without it escalate is tied to 0.
module attendant_call_dispatcher #(
    parameter int NUM_SEATS  = 8,
    parameter int SEAT_W     = 3,
    parameter int ESC_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_SEATS-1:0] seat_light,
    input  logic                 attendant_ack,
    output logic [NUM_SEATS-1:0] seat_cancel,
    output logic                 active_valid,
    output logic [SEAT_W-1:0]    active_seat,
    output logic                 call_pending,
    output logic                 escalate,
    output logic [7:0]           serviced_count
);

    // Reject configurations the dispatcher cannot index or time correctly.
    if ((NUM_SEATS < 2) || (NUM_SEATS > 16) || ((2 ** SEAT_W) < NUM_SEATS) || (ESC_CYCLES < 2)) begin : g_bad_params
        $error("attendant_call_dispatcher: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_CANCEL  = 2'd2,
        ST_SETTLE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [SEAT_W-1:0]     r_rr_ptr;
    logic [SEAT_W-1:0]     r_active_seat;
    logic                  r_active_valid;
    logic [NUM_SEATS-1:0]  r_seat_cancel;
    logic                  r_call_pending;
    logic [7:0]            r_serviced_count;

    logic                  w_found;
    logic [SEAT_W-1:0]     w_sel_seat;
    logic [SEAT_W-1:0]     w_next_ptr;
    logic                  w_seat_lit;
    logic [NUM_SEATS-1:0]  w_cancel_onehot;

    // First lit seat at or above rr_ptr, wrapping at NUM_SEATS. Only real
    // seat indices are ever produced because the wrap happens before the
    // light is looked up.
    always_comb begin
        int                idx;
        logic [SEAT_W-1:0] cand;
        w_found    = 1'b0;
        w_sel_seat = '0;
        idx        = 0;
        cand       = '0;
        for (int k = 0; k < NUM_SEATS; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_SEATS) begin
                idx = idx - NUM_SEATS;
            end
            cand = idx[SEAT_W-1:0];
            if (!w_found && seat_light[cand]) begin
                w_found    = 1'b1;
                w_sel_seat = cand;
            end
        end
    end

    assign w_seat_lit = seat_light[r_active_seat];

    // Pointer moves past the seat just presented so a held call cannot
    // starve the other seats.
    assign w_next_ptr = (r_active_seat == SEAT_W'(NUM_SEATS - 1)) ? '0
                                                                  : r_active_seat + SEAT_W'(1);

    always_comb begin
        w_cancel_onehot                = '0;
        w_cancel_onehot[r_active_seat] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state          <= ST_IDLE;
            r_rr_ptr         <= '0;
            r_active_seat    <= '0;
            r_active_valid   <= 1'b0;
            r_seat_cancel    <= '0;
            r_call_pending   <= 1'b0;
            r_serviced_count <= '0;
        end else begin
            r_call_pending <= |seat_light;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_active_seat  <= w_sel_seat;
                        r_active_valid <= 1'b1;
                        r_state        <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    // Withdrawal wins over a simultaneous ack.
                    if (!w_seat_lit) begin
                        r_state        <= ST_IDLE;
                        r_active_valid <= 1'b0;
                        r_active_seat  <= '0;
                        r_rr_ptr       <= w_next_ptr;
                    end else if (attendant_ack) begin
                        r_state       <= ST_CANCEL;
                        r_seat_cancel <= w_cancel_onehot;
                        r_rr_ptr      <= w_next_ptr;
                        if (r_serviced_count != 8'hFF) begin
                            r_serviced_count <= r_serviced_count + 8'd1;
                        end
                    end
                end
                ST_CANCEL: begin
                    r_seat_cancel  <= '0;
                    r_active_valid <= 1'b0;
                    r_active_seat  <= '0;
                    r_state        <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    // Quiet cycle so the seat register's light drop is seen
                    // before the next search.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CALL_ESCALATE_EN
    localparam int                ESC_CW   = $clog2(ESC_CYCLES + 1);
    localparam logic [ESC_CW-1:0] ESC_LAST = ESC_CW'(ESC_CYCLES - 1);
    localparam logic [ESC_CW-1:0] ESC_MAX  = ESC_CW'(ESC_CYCLES);

    logic [ESC_CW-1:0] r_esc_cnt;
    logic              r_escalate;
    logic              w_hold_present;

    // True on every edge that ends a PRESENT cycle without leaving PRESENT.
    assign w_hold_present = (r_state == ST_PRESENT) && w_seat_lit && !attendant_ack;

    // r_esc_cnt holds completed PRESENT cycles; any cycle outside PRESENT
    // (including the entry edge) clears it, so each presentation starts at 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_esc_cnt  <= '0;
            r_escalate <= 1'b0;
        end else if (w_hold_present) begin
            if (r_esc_cnt >= ESC_LAST) begin
                r_escalate <= 1'b1;
            end
            if (r_esc_cnt != ESC_MAX) begin
                r_esc_cnt <= r_esc_cnt + ESC_CW'(1);
            end
        end else begin
            r_esc_cnt  <= '0;
            r_escalate <= 1'b0;
        end
    end

    assign escalate = r_escalate;
`else
    assign escalate = 1'b0;
`endif

    assign seat_cancel    = r_seat_cancel;
    assign active_valid   = r_active_valid;
    assign active_seat    = r_active_seat;
    assign call_pending   = r_call_pending;
    assign serviced_count = r_serviced_count;

endmodule
